gray_display_ctrl: RTL and testbench
====================================

# gray_display_ctrl

Controller for the 4-bit Gray-code switch-to-display path. It synchronizes and debounces the raw Gray switch inputs, then converts the accepted code to binary. It drives the binary LEDs and time-multiplexes two active-low 7-segment digits showing the decimal value 0–15. It sits between the board DIP switches and the LED/7-segment pins, and sequences the Gray→binary decode path.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive equal synchronized samples required to accept a new code; ≥2. Synthesis sets the board value.
- `SCAN_CYCLES`, default 8: clock cycles each digit stays enabled; ≥2.
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `gray_i` in 4: raw Gray-code switches, asynchronous to `clk`.
- `leds_o` out 4: accepted value in binary, registered; bit 3 = MSB.
- `value_o` out 4: same as `leds_o`, for downstream consumers.
- `update_o` out 1: one-cycle pulse when a new value is accepted.
- `seg_o` out 7: `{g,f,e,d,c,b,a}`, active-low, registered.
- `an_o` out 2: digit enables, active-low. `an_o[0]` = units, `an_o[1]` = tens.

## Operation
- Reset values:
  - `value_o`/`leds_o` = 0; `update_o` = 0.
  - `seg_o` = 7'h7F (blank); `an_o` = 2'b11.
  - Sync flops, candidate and counters = 0; scan digit = UNITS.
- Synchronizer: 2 flops, `sync1` then `sync2`.
- Debounce, evaluated each cycle:
  - If `sync2` ≠ `cand`: `cand` ← `sync2`, `cnt` ← 0.
  - Else if `cnt` = `DEBOUNCE_CYCLES`-1: `cnt` holds. If gray2bin(`cand`) ≠ `value`, then `value` ← gray2bin(`cand`) and `update_o` = 1 for exactly one cycle.
  - Else `cnt` ← `cnt`+1.
- gray2bin: b3 = g3; b_i = b_{i+1} ^ g_i.
- A glitch shorter than the debounce window restarts the window and never produces an update.
- Re-accepting an unchanged value produces no pulse.
- Scan FSM, 2 states:
  - UNITS → TENS when `scan_cnt` = `SCAN_CYCLES`-1; `scan_cnt` wraps to 0.
  - TENS → UNITS on the same condition.
- Digit arithmetic (no divider):
  - tens = (`value` ≥ 10).
  - units = tens ? `value`−10 : `value`, 4-bit.
- UNITS state: `an_o` = 2'b10; `seg_o` = enc(units).
- TENS state: `an_o` = 2'b01; `seg_o` = enc(1) if tens, else blank (leading-zero blanking; the anode stays enabled for constant duty).
- Encodings:
  - 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000, 4 = 7'b0011001
  - 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000, 8 = 7'b0000000, 9 = 7'b0010000
- A value update mid-digit changes `seg_o` on the next cycle. The scan phase is not restarted.
- Asserting `rst_n` low at any time forces all reset values immediately, including mid-debounce and mid-scan. An in-progress candidate is discarded.

## Timing
- All outputs are registered.
- An input change first sampled by `sync1` at edge t produces:
  - `cand` updated at edge t+2;
  - `value_o`/`leds_o`/`update_o` at edge t+2+`DEBOUNCE_CYCLES` (t+6 for the default);
  - `seg_o` reflecting the new value one edge later.
- First enabled digit after reset release: UNITS, at the first `clk` edge with `rst_n` high.
- Scan period: 2×`SCAN_CYCLES` cycles.
- `update_o` pulses are separated by at least `DEBOUNCE_CYCLES`+1 cycles.

## Structure
- Package `disp_pkg`:
  - `digit_e` enum (UNITS, TENS);
  - `SEG_BLANK`;
  - seven-segment code constant array `SEG_CODE[0:9]`;
  - function `gray2bin`.
- Sub-module `gray_debounce`: synchronizer + debounce, outputs `value`/`update`, parameter `DEBOUNCE_CYCLES`.
- Top `gray_display_ctrl` holds the scan FSM and segment drive.

## Test plan
- Reset, `gray_i` = 4'b0000 → `leds_o` = 0, `update_o` never pulses; `an_o` alternates 2'b10 / 2'b01 every 8 cycles; `seg_o` = 7'b1000000 (units), 7'h7F (tens).
- `gray_i` 0000→1011 (13), held → `leds_o` = 4'b1101 exactly 6 edges after first sample; one `update_o` pulse; units `seg_o` = 7'b0110000, tens `seg_o` = 7'b1111001.
- `gray_i` toggles 0000→0001→0000 with the 0001 held 3 cycles → no update; `leds_o` stays 0.
- Sweep all 16 Gray codes (0000, 0001, 0011, … 1000), each held 20 cycles → `leds_o` = 0..15 in order; 15 pulses; tens digit blank for 0–9.
- `rst_n` pulsed low mid-debounce of 1000 (15) and mid-TENS → outputs return to reset values asynchronously. After release with 1000 still applied: `leds_o` = 15 after 6 edges and the scan restarts at UNITS.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types, segment codes and Gray decode for the switch-to-display path.
package disp_pkg;

  localparam int unsigned VAL_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 2;

  // Which digit the scan is currently driving.
  typedef enum logic {
    UNITS = 1'b0,
    TENS  = 1'b1
  } digit_e;

  // Active-low {g,f,e,d,c,b,a}; all segments off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_CODE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [VAL_W-1:0] gray2bin(input logic [VAL_W-1:0] g);
    logic [VAL_W-1:0] b;
    b[VAL_W-1] = g[VAL_W-1];
    for (int i = int'(VAL_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_debounce.sv
// Two-flop synchronizer and debounce filter producing the accepted binary value.
module gray_debounce
  import disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] gray,
  output logic [VAL_W-1:0] value,
  output logic             update
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [VAL_W-1:0] sync1;
  logic [VAL_W-1:0] sync2;
  logic [VAL_W-1:0] cand;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous switch inputs into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gray;
      sync2 <= sync1;
    end
  end

  // Any change restarts the window; a full stable window accepts the code once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= '0;
      cnt    <= '0;
      value  <= '0;
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        if (gray2bin(cand) != value) begin
          value  <= gray2bin(cand);
          update <= 1'b1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gray_display_ctrl.sv
// Gray switch decode with binary LEDs and a two-digit multiplexed 7-segment display.
module gray_display_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SCAN_CYCLES     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VAL_W-1:0] gray_i,
  output logic [VAL_W-1:0] leds_o,
  output logic [VAL_W-1:0] value_o,
  output logic             update_o,
  output logic [SEG_W-1:0] seg_o,
  output logic [AN_W-1:0]  an_o
);

  localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);

  logic [VAL_W-1:0]  value;
  logic              update;
  logic              tens;
  logic [VAL_W-1:0]  units;
  digit_e            state_q;
  digit_e            state_d;
  logic [SCAN_W-1:0] scan_cnt_q;
  logic [SCAN_W-1:0] scan_cnt_d;
  logic [SEG_W-1:0]  seg_d;
  logic [AN_W-1:0]   an_d;

  gray_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .gray  (gray_i),
    .value (value),
    .update(update)
  );

  assign leds_o   = value;
  assign value_o  = value;
  assign update_o = update;

  // Decimal split of 0..15 without a divider.
  assign tens  = (value >= VAL_W'(10));
  assign units = tens ? (value - VAL_W'(10)) : value;

  // Scan state and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNITS;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  // Next scan state and the digit drive for the current state.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    seg_d      = SEG_BLANK;
    an_d       = 2'b11;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
    end
    case (state_q)
      UNITS: begin
        an_d  = 2'b10;
        seg_d = SEG_CODE[units];
        if (scan_cnt_q == SCAN_MAX) state_d = TENS;
      end
      TENS: begin
        an_d  = 2'b01;
        seg_d = tens ? SEG_CODE[1] : SEG_BLANK;
        if (scan_cnt_q == SCAN_MAX) state_d = UNITS;
      end
      default: begin
        state_d = UNITS;
      end
    endcase
  end

  // Registered pin drive; the tens anode stays on even when blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o <= SEG_BLANK;
      an_o  <= 2'b11;
    end else begin
      seg_o <= seg_d;
      an_o  <= an_d;
    end
  end

endmodule

// File: tb/tb_gray_display_ctrl.sv
// Randomized and directed bench with a behavioural model for gray_display_ctrl.
module tb_gray_display_ctrl;

  localparam int D = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gray_i;
  logic [3:0] leds_o;
  logic [3:0] value_o;
  logic       update_o;
  logic [6:0] seg_o;
  logic [1:0] an_o;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  bit chk_en   = 1'b0;

  gray_display_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SCAN_CYCLES    (S)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gray_i  (gray_i),
    .leds_o  (leds_o),
    .value_o (value_o),
    .update_o(update_o),
    .seg_o   (seg_o),
    .an_o    (an_o)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Binary value whose reflected Gray code equals g.
  function automatic logic [3:0] g2b(input logic [3:0] g);
    for (int i = 0; i < 16; i++) begin
      if (4'(i ^ (i >> 1)) == g) return 4'(i);
    end
    return 4'h0;
  endfunction

  // Model state: a two-sample delay line, then a window of the last D+1
  // synchronized samples. A code is accepted when the whole window agrees.
  logic [3:0] pipe [$];
  logic [3:0] win  [$];
  int         m_n;
  logic [3:0] m_value;
  logic       m_update;
  logic [6:0] m_seg;
  logic [1:0] m_an;
  logic [3:0] s;
  bit         stable;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe     = '{4'h0, 4'h0};
      win      = '{4'h0};
      m_n      = 0;
      m_value  = 4'h0;
      m_update = 1'b0;
      m_seg    = 7'h7F;
      m_an     = 2'b11;
    end else begin
      m_n++;
      if ((((m_n - 1) / S) % 2) == 0) begin
        m_an  = 2'b10;
        m_seg = seg_tab[int'(m_value) % 10];
      end else begin
        m_an  = 2'b01;
        m_seg = (m_value >= 4'd10) ? seg_tab[1] : 7'h7F;
      end
      pipe.push_back(gray_i);
      s = pipe.pop_front();
      win.push_back(s);
      if (win.size() > D + 1) void'(win.pop_front());
      m_update = 1'b0;
      stable   = (win.size() == D + 1);
      foreach (win[i]) if (win[i] != s) stable = 1'b0;
      if (stable && g2b(s) != m_value) begin
        m_value  = g2b(s);
        m_update = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("leds",   32'(leds_o),   32'(m_value));
      chk("value",  32'(value_o),  32'(m_value));
      chk("update", 32'(update_o), 32'(m_update));
      chk("seg",    32'(seg_o),    32'(m_seg));
      chk("an",     32'(an_o),     32'(m_an));
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && update_o === 1'b1) pulses++;
  end

  task automatic wait_an(input logic [1:0] want);
    int k = 0;
    while (an_o !== want && k < 4 * S) begin
      @(negedge clk);
      k++;
    end
    chk("wait_an", 32'(an_o), 32'(want));
  endtask

  initial begin
    gray_i = 4'h0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_an",   32'(an_o),   32'(2'b11));
    chk("rst_seg",  32'(seg_o),  32'(7'h7F));
    chk("rst_leds", 32'(leds_o), 32'(0));

    // Idle at zero: units shows 0, tens blank, 8-cycle dwell.
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_an",  32'(an_o),  32'(2'b10));
    chk("first_seg", 32'(seg_o), 32'(7'b1000000));
    repeat (7) @(negedge clk);
    chk("dwell_units", 32'(an_o), 32'(2'b10));
    @(negedge clk);
    chk("dwell_tens", 32'(an_o),  32'(2'b01));
    chk("tens_blank", 32'(seg_o), 32'(7'h7F));
    repeat (30) @(negedge clk);
    chk("idle_pulses", 32'(pulses), 32'(0));

    // Glitch shorter than the window.
    gray_i = 4'b0001;
    repeat (3) @(negedge clk);
    gray_i = 4'b0000;
    repeat (20) @(negedge clk);
    chk("glitch_pulses", 32'(pulses), 32'(0));
    chk("glitch_leds",   32'(leds_o), 32'(0));

    // Gray 1011 -> 13, accepted six edges after the first sample.
    gray_i = 4'b1011;
    repeat (6) @(negedge clk);
    chk("lat_before", 32'(leds_o), 32'(0));
    @(negedge clk);
    chk("lat_leds",   32'(leds_o),   32'(4'b1101));
    chk("lat_update", 32'(update_o), 32'(1));
    @(negedge clk);
    wait_an(2'b10);
    chk("units13", 32'(seg_o), 32'(7'b0110000));
    wait_an(2'b01);
    chk("tens13",  32'(seg_o), 32'(7'b1111001));
    chk("pulses13", 32'(pulses), 32'(1));

    // Sweep all Gray codes in binary order.
    gray_i = 4'h0;
    repeat (20) @(negedge clk);
    pulses = 0;
    for (int i = 1; i < 16; i++) begin
      gray_i = 4'(i ^ (i >> 1));
      repeat (20) @(negedge clk);
      chk("sweep_leds", 32'(leds_o), 32'(i));
    end
    chk("sweep_pulses", 32'(pulses), 32'(15));

    // Random holds, including many shorter than the window.
    for (int i = 0; i < 300; i++) begin
      gray_i = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end

    // Asynchronous reset mid-debounce and mid-TENS.
    gray_i = 4'h0;
    repeat (20) @(negedge clk);
    wait_an(2'b01);
    gray_i = 4'b1000;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_leds",   32'(leds_o),   32'(0));
    chk("arst_update", 32'(update_o), 32'(0));
    chk("arst_seg",    32'(seg_o),    32'(7'h7F));
    chk("arst_an",     32'(an_o),     32'(2'b11));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_an", 32'(an_o), 32'(2'b10));
    repeat (5) @(negedge clk);
    chk("rel_before", 32'(leds_o), 32'(0));
    @(negedge clk);
    chk("rel_leds",   32'(leds_o),   32'(15));
    chk("rel_update", 32'(update_o), 32'(1));
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
